// File: rtl/qif_neuron_array_if.sv
// Stimulus / readout bus of the QIF neuron array: input-switch side drives en and stim,
// the array returns per-update results and the running spike count.
interface qif_neuron_array_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                    en;
  logic [N_CH*WIDTH-1:0]   stim;
  logic                    upd_valid;
  logic [CH_W-1:0]         upd_ch;
  logic signed [WIDTH-1:0] v_out;
  logic                    spike;
  logic [7:0]              spike_cnt;

  modport master (
    output en, stim,
    input  upd_valid, upd_ch, v_out, spike, spike_cnt
  );

  modport slave (
    input  en, stim,
    output upd_valid, upd_ch, v_out, spike, spike_cnt
  );
endinterface

// File: rtl/qif_neuron_array.sv
// N_CH-channel quadratic integrate-and-fire neuron array sharing one saturating datapath;
// channels are visited round-robin, one per enabled cycle.
module qif_neuron_array #(
  parameter int WIDTH    = 8,
  parameter int N_CH     = 4,
  parameter int IN_SHIFT = 2,
  parameter int Q_SHIFT  = 3,
  parameter int THRESH   = 50,
  parameter int V_RESET  = -20,
  parameter int V_INIT   = 0,
  parameter int REFRAC   = 2
) (
  input  logic             clk,
  input  logic             reset,
  qif_neuron_array_if.slave bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int RW   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int SW   = 2*WIDTH + 2;
  localparam int PW   = 2*WIDTH;

  typedef logic signed [WIDTH-1:0] pot_t;
  typedef logic [RW-1:0]           ref_t;
  typedef logic [CH_W-1:0]         ch_t;

  localparam pot_t THRESH_V  = pot_t'(THRESH);
  localparam pot_t V_RESET_V = pot_t'(V_RESET);
  localparam pot_t V_INIT_V  = pot_t'(V_INIT);
  localparam ref_t REFRAC_V  = ref_t'(REFRAC);
  localparam ch_t  LAST_CH   = ch_t'(N_CH - 1);

  localparam logic signed [SW-1:0] SAT_HI = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_LO = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  // Per-channel state
  pot_t v_mem  [N_CH];
  ref_t rf_mem [N_CH];
  ch_t  ch_sel;

  // Registered outputs
  logic       upd_valid_q;
  ch_t        upd_ch_q;
  pot_t       v_out_q;
  logic       spike_q;
  logic [7:0] spike_cnt_q;

  // Datapath for the currently selected channel
  pot_t                    cur_v;
  ref_t                    cur_r;
  logic [WIDTH-1:0]        cur_stim;
  pot_t                    q;
  logic signed [PW-1:0]    q_ext;
  logic signed [PW-1:0]    q_sq;
  logic signed [SW-1:0]    sum;
  pot_t                    sat_v;
  pot_t                    v_next;
  ref_t                    r_next;
  logic                    fire;
  ch_t                     ch_next;

  // NOTE: always_comb with every output given a default first, so no path can infer a latch.
  always_comb begin
    cur_v    = v_mem[ch_sel];
    cur_r    = rf_mem[ch_sel];
    cur_stim = bus.stim[ch_sel*WIDTH +: WIDTH];
    q        = cur_v >>> Q_SHIFT;
    q_ext    = {{WIDTH{q[WIDTH-1]}}, q};
    q_sq     = q_ext * q_ext;
    // Wide enough that v + stim + q^2 can never wrap before clamping.
    sum      = {{(SW-WIDTH){cur_v[WIDTH-1]}}, cur_v}
             + {{(SW-WIDTH){1'b0}}, cur_stim >> IN_SHIFT}
             + {{(SW-PW){q_sq[PW-1]}}, q_sq};
    if (sum > SAT_HI)      sat_v = SAT_HI[WIDTH-1:0];
    else if (sum < SAT_LO) sat_v = SAT_LO[WIDTH-1:0];
    else                   sat_v = sum[WIDTH-1:0];

    v_next = sat_v;
    r_next = cur_r;
    fire   = 1'b0;
    if (cur_r != '0) begin
      v_next = V_RESET_V;
      r_next = cur_r - 1'b1;
    end else if (cur_v >= THRESH_V) begin
      // Threshold is tested on the stored value, so a crossing fires on the next visit.
      v_next = V_RESET_V;
      r_next = REFRAC_V;
      fire   = 1'b1;
    end

    ch_next = (ch_sel == LAST_CH) ? '0 : ch_sel + 1'b1;
  end

  // NOTE: the channel arrays are flops, not RAM, and are cleared by reset like any other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_CH; k++) begin
        v_mem[k]  <= V_INIT_V;
        rf_mem[k] <= '0;
      end
      ch_sel      <= '0;
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
      v_out_q     <= V_INIT_V;
      spike_q     <= 1'b0;
      spike_cnt_q <= '0;
    end else if (bus.en) begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      v_mem[ch_sel]  <= v_next;
      rf_mem[ch_sel] <= r_next;
      ch_sel         <= ch_next;
      upd_valid_q    <= 1'b1;
      upd_ch_q       <= ch_sel;
      v_out_q        <= v_next;
      spike_q        <= fire;
      if (fire) spike_cnt_q <= spike_cnt_q + 8'd1;
    end else begin
      upd_valid_q <= 1'b0;
      spike_q     <= 1'b0;
    end
  end

  assign bus.upd_valid = upd_valid_q;
  assign bus.upd_ch    = upd_ch_q;
  assign bus.v_out     = v_out_q;
  assign bus.spike     = spike_q;
  assign bus.spike_cnt = spike_cnt_q;
endmodule

// File: tb/tb_qif_neuron_array.sv
// Scoreboard bench for qif_neuron_array: two instances (THRESH 50 and 127) share stimulus and
// are compared against an integer reference model of the neuron rules.
module tb_qif_neuron_array;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  qif_neuron_array_if #(.WIDTH(W), .N_CH(N)) bus0 ();
  qif_neuron_array_if #(.WIDTH(W), .N_CH(N)) bus1 ();

  qif_neuron_array #(.WIDTH(W), .N_CH(N), .THRESH(50))  u0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  qif_neuron_array #(.WIDTH(W), .N_CH(N), .THRESH(127)) u1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  typedef struct {
    int ch;
    int v;
    bit sp;
    int cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int mv   [2][N];
  int mr   [2][N];
  int mch  [2];
  int mcnt [2];
  int last_v [2];

  // Directed-observation logs
  bit log_en [2];
  int obs_v  [$];
  bit obs_sp [$];
  bit wrapped = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got %0d, expected %0d", name, act, req);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < N; c++) begin
        mv[k][c] = 0;
        mr[k][c] = 0;
      end
      mch[k]    = 0;
      mcnt[k]   = 0;
      last_v[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic [N*W-1:0] s);
    exp_t e;
    int c, v, st, qq, nv, thr;
    bit sp;
    thr = (k == 0) ? 50 : 127;
    c   = mch[k];
    v   = mv[k][c];
    st  = int'(s[c*W +: W]);
    sp  = 1'b0;
    if (mr[k][c] > 0) begin
      nv = -20;
      mr[k][c]--;
    end else if (v >= thr) begin
      nv = -20;
      mr[k][c] = 2;
      sp = 1'b1;
      mcnt[k] = (mcnt[k] + 1) % 256;
    end else begin
      qq = v >>> 3;
      nv = v + st / 4 + qq * qq;
      if (nv > 127)  nv = 127;
      if (nv < -128) nv = -128;
    end
    mv[k][c] = nv;
    mch[k]   = (c + 1) % N;
    e.ch = c; e.v = nv; e.sp = sp; e.cnt = mcnt[k];
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic monitor(input int k, input bit valid, input int ch, input int v,
                         input bit sp, input int cnt);
    exp_t e;
    if (valid) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        check($sformatf("dut%0d_unexpected_update", k), 1, 0);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("dut%0d_upd_ch", k), ch, e.ch);
        check($sformatf("dut%0d_v_out", k), v, e.v);
        check($sformatf("dut%0d_spike", k), int'(sp), int'(e.sp));
        check($sformatf("dut%0d_spike_cnt", k), cnt, e.cnt);
        last_v[k] = e.v;
        if (log_en[k] && e.ch == 0) begin
          obs_v.push_back(v);
          obs_sp.push_back(sp);
        end
        if (k == 0 && e.sp && e.cnt == 0) wrapped = 1'b1;
      end
    end else begin
      check($sformatf("dut%0d_idle_spike", k), int'(sp), 0);
      check($sformatf("dut%0d_idle_hold_v", k), v, last_v[k]);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      monitor(0, bus0.upd_valid, int'(bus0.upd_ch), int'(bus0.v_out), bus0.spike, int'(bus0.spike_cnt));
      monitor(1, bus1.upd_valid, int'(bus1.upd_ch), int'(bus1.v_out), bus1.spike, int'(bus1.spike_cnt));
    end
  end

  // One cycle of stimulus; returns #1 after the edge it was applied to.
  task automatic step(input bit e, input logic [N*W-1:0] s);
    @(negedge clk);
    bus0.en = e; bus0.stim = s;
    bus1.en = e; bus1.stim = s;
    if (e) begin
      model_step(0, s);
      model_step(1, s);
    end
    @(posedge clk);
    #1;
  endtask

  // Reset is raised and dropped between edges to exercise its asynchronous behaviour.
  task automatic do_reset();
    bus0.en = 1'b0; bus1.en = 1'b0;
    @(negedge clk);
    #1;
    check("pending_dut0", q0.size(), 0);
    check("pending_dut1", q1.size(), 0);
    reset = 1'b1;
    #1;
    check("rst_upd_valid", int'(bus0.upd_valid), 0);
    check("rst_upd_ch", int'(bus0.upd_ch), 0);
    check("rst_v_out", int'(bus0.v_out), 0);
    check("rst_spike", int'(bus0.spike), 0);
    check("rst_spike_cnt", int'(bus0.spike_cnt), 0);
    check("rst_v_out_dut1", int'(bus1.v_out), 0);
    model_reset();
    q0.delete(); q1.delete();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.en = 1'b0; bus0.stim = '0;
    bus1.en = 1'b0; bus1.stim = '0;
    log_en[0] = 1'b0; log_en[1] = 1'b0;
    model_reset();
    do_reset();

    // Zero stimulus: plain round-robin sweep
    for (int i = 0; i < 8; i++) step(1'b1, '0);
    check("t1_spike_cnt", int'(bus0.spike_cnt), 0);

    // Single-channel drive to a spike and through refractory
    do_reset();
    log_en[0] = 1'b1;
    for (int i = 0; i < 32; i++) step(1'b1, 32'd40);
    step(1'b0, 32'd40);
    log_en[0] = 1'b0;
    begin
      int exp_v[8];
      bit exp_s[8];
      exp_v = '{10, 21, 35, 61, -20, -20, -20, -1};
      exp_s = '{0, 0, 0, 0, 1, 0, 0, 0};
      check("t2_visits", obs_v.size(), 8);
      for (int i = 0; i < 8 && i < obs_v.size(); i++) begin
        check($sformatf("t2_v_visit%0d", i), obs_v[i], exp_v[i]);
        check($sformatf("t2_sp_visit%0d", i), int'(obs_sp[i]), int'(exp_s[i]));
      end
      check("t2_spike_cnt", int'(bus0.spike_cnt), 1);
    end
    obs_v.delete(); obs_sp.delete();

    // Saturation on the high-threshold instance
    do_reset();
    log_en[1] = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b1, 32'd255);
    step(1'b0, 32'd255);
    log_en[1] = 1'b0;
    begin
      int exp_v[3];
      bit exp_s[3];
      exp_v = '{63, 127, -20};
      exp_s = '{0, 0, 1};
      check("t3_visits", obs_v.size(), 3);
      for (int i = 0; i < 3 && i < obs_v.size(); i++) begin
        check($sformatf("t3_v_visit%0d", i), obs_v[i], exp_v[i]);
        check($sformatf("t3_sp_visit%0d", i), int'(obs_sp[i]), int'(exp_s[i]));
      end
    end
    obs_v.delete(); obs_sp.delete();

    // Enable dropped mid-sweep at channel 2
    do_reset();
    step(1'b1, 32'h0c0b0a09);
    step(1'b1, 32'h0c0b0a09);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'hffffffff);
      check("t4_idle_valid", int'(bus0.upd_valid), 0);
    end
    step(1'b1, 32'h0c0b0a09);
    check("t4_resume_ch", int'(bus0.upd_ch), 2);
    check("t4_resume_valid", int'(bus0.upd_valid), 1);

    // Asynchronous reset mid-sweep, then restart from channel 0
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 32'd40);
    check("t5_pre_v", int'(bus0.v_out), 35);
    check("t5_pre_ch", int'(bus0.upd_ch), 0);
    do_reset();
    step(1'b1, 32'd40);
    check("t5_post_ch", int'(bus0.upd_ch), 0);
    check("t5_post_v", int'(bus0.v_out), 10);

    // Long full-scale drive: spike counter must wrap
    do_reset();
    for (int i = 0; i < 1400; i++) step(1'b1, 32'hffffffff);
    check("t6_cnt_wrapped", int'(wrapped), 1);

    // Random enable and stimulus
    do_reset();
    for (int i = 0; i < 600; i++) step($urandom_range(0, 3) != 0, $urandom);

    step(1'b0, '0);
    step(1'b0, '0);
    check("final_drain_dut0", q0.size(), 0);
    check("final_drain_dut1", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
